monitor_btn_ctrl: RTL and testbench

//  Upstream input stage for the up/down event counter. Conditions two raw push-buttons
//  (up, down): 2-FF synchronise, debounce, hold-to-auto-repeat. Produces the counter's

---
 rtl/monitor_btn_ctrl_if.sv | 34 +++
 rtl/monitor_btn_ctrl.sv | 156 +++++++++++++++
 tb/tb_monitor_btn_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/monitor_btn_ctrl_if.sv
// ---------------------------------------------------------------------------
// monitor_btn_ctrl_if
// Bundles the push-button inputs and the counter control outputs of the
// button conditioning stage.
//   btn_up  : raw up button (asynchronous, may bounce)
//   btn_dn  : raw down button (asynchronous, may bounce)
//   change  : 1-cycle count-step strobe
//   on_off  : step direction, 1 = increment, 0 = decrement
//   active  : high while one button is accepted and held
// master drives the buttons (board / bench side); slave is the conditioner.
// ---------------------------------------------------------------------------
interface monitor_btn_ctrl_if;
    logic btn_up;
    logic btn_dn;
    logic change;
    logic on_off;
    logic active;

    modport master (
        output btn_up,
        output btn_dn,
        input  change,
        input  on_off,
        input  active
    );

    modport slave (
        input  btn_up,
        input  btn_dn,
        output change,
        output on_off,
        output active
    );
endinterface

// File: rtl/monitor_btn_ctrl.sv
// ---------------------------------------------------------------------------
// monitor_btn_ctrl
// Input stage of the up/down event counter: synchronises two raw buttons,
// debounces them and turns a held button into a first step plus auto-repeat
// steps. Outputs drive the counter's change/on_off inputs directly.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous reset, active low
//   bus : slave side of monitor_btn_ctrl_if (btn_up, btn_dn in;
//         change, on_off, active out, all outputs registered)
// ---------------------------------------------------------------------------
module monitor_btn_ctrl #(
    parameter int CNT_W           = 16,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 64,
    parameter int REPEAT_CYCLES   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    monitor_btn_ctrl_if.slave    bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HOLD   = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;
    localparam logic [1:0] ST_LOCK   = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    // bit 0 = up button, bit 1 = down button
    logic [1:0]       sync1_r;
    logic [1:0]       sync2_r;
    logic [1:0]       db_r;
    logic [CNT_W-1:0] db_cnt_r [2];

    logic [1:0]       state_r;
    logic [1:0]       state_s;
    logic [CNT_W-1:0] timer_r;
    logic [CNT_W-1:0] timer_s;
    logic             change_r;
    logic             change_s;
    logic             on_off_r;
    logic             on_off_s;
    logic             active_r;
    logic             active_s;
    logic             db_up_s;
    logic             db_dn_s;
    logic             held_s;

    assign db_up_s = db_r[0];
    assign db_dn_s = db_r[1];
    // The button that started the current hold, selected by the latched direction.
    assign held_s  = on_off_r ? db_up_s : db_dn_s;

    // Two-flop synchroniser and per-button debounce counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r <= 2'b00;
            sync2_r <= 2'b00;
            db_r    <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                db_cnt_r[i] <= CNT_ZERO;
            end
        end else begin
            sync1_r <= {bus.btn_dn, bus.btn_up};
            sync2_r <= sync1_r;
            for (int i = 0; i < 2; i++) begin
                if (sync2_r[i] == db_r[i]) begin
                    db_cnt_r[i] <= CNT_ZERO;
                end else if (db_cnt_r[i] == DB_LAST) begin
                    // Level has differed for DEBOUNCE_CYCLES edges: accept it.
                    db_r[i]     <= sync2_r[i];
                    db_cnt_r[i] <= CNT_ZERO;
                end else if (db_cnt_r[i] != CNT_MAX) begin
                    db_cnt_r[i] <= db_cnt_r[i] + CNT_ONE;
                end else begin
                    db_cnt_r[i] <= db_cnt_r[i];
                end
            end
        end
    end

    // Next-state logic: both-pressed beats release beats timer expiry.
    always_comb begin
        state_s  = state_r;
        timer_s  = timer_r;
        change_s = 1'b0;
        on_off_s = on_off_r;
        case (state_r)
            ST_IDLE: begin
                if (db_up_s && db_dn_s) begin
                    state_s = ST_LOCK;
                end else if (db_up_s || db_dn_s) begin
                    state_s  = ST_HOLD;
                    timer_s  = CNT_ZERO;
                    change_s = 1'b1;
                    on_off_s = db_up_s;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_HOLD, ST_REPEAT: begin
                if (db_up_s && db_dn_s) begin
                    state_s = ST_LOCK;
                end else if (!held_s) begin
                    state_s = ST_IDLE;
                end else if (timer_r == ((state_r == ST_HOLD) ? HOLD_LAST : REPEAT_LAST)) begin
                    state_s  = ST_REPEAT;
                    timer_s  = CNT_ZERO;
                    change_s = 1'b1;
                end else begin
                    timer_s = timer_r + CNT_ONE;
                end
            end
            ST_LOCK: begin
                if (!db_up_s && !db_dn_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_LOCK;
                end
            end
            default: begin
                state_s = ST_IDLE;
                timer_s = CNT_ZERO;
            end
        endcase
        active_s = (state_s == ST_HOLD) || (state_s == ST_REPEAT);
    end

    // State, timer and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            timer_r  <= CNT_ZERO;
            change_r <= 1'b0;
            on_off_r <= 1'b0;
            active_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            timer_r  <= timer_s;
            change_r <= change_s;
            on_off_r <= on_off_s;
            active_r <= active_s;
        end
    end

    assign bus.change = change_r;
    assign bus.on_off = on_off_r;
    assign bus.active = active_r;

endmodule

// File: tb/tb_monitor_btn_ctrl.sv
// ---------------------------------------------------------------------------
// tb_monitor_btn_ctrl
// Self-checking bench for monitor_btn_ctrl. A behavioural model (sample
// history, stable-run debounce, hold age arithmetic) runs alongside the DUT;
// directed scenarios also check absolute event times.
// ---------------------------------------------------------------------------
module tb_monitor_btn_ctrl;

    localparam int D = 16;
    localparam int H = 64;
    localparam int R = 16;

    logic clk;
    logic rst;
    monitor_btn_ctrl_if bus ();

    monitor_btn_ctrl #(
        .CNT_W(16), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int start = 0;
    int m_err = 0;
    int m_err_cyc = 0;
    logic [2:0] m_err_got, m_err_exp;
    logic [2:0] obs3, exp3;
    int ev_q[$];
    bit ev_dir_q[$];

    // behavioural model state
    bit m_sa_up, m_s_up, m_db_up, m_sa_dn, m_s_dn, m_db_dn;
    int m_run_up, m_run_dn;
    int m_mode;           // 0 idle, 1 one button held, 2 locked out
    bit m_dir;
    int m_age;            // edges since the first event of the current hold
    bit e_change, e_on_off, e_active;

    task automatic model_reset();
        m_sa_up = 0; m_s_up = 0; m_db_up = 0; m_run_up = 0;
        m_sa_dn = 0; m_s_dn = 0; m_db_dn = 0; m_run_dn = 0;
        m_mode = 0; m_dir = 0; m_age = 0;
        e_change = 0; e_on_off = 0; e_active = 0;
    endtask

    task automatic model_step();
        bit u, d;
        if (!rst) begin
            model_reset();
        end else begin
            u = m_db_up;
            d = m_db_dn;
            e_change = 0;
            if (m_mode == 0) begin
                if (u && d) m_mode = 2;
                else if (u || d) begin
                    m_mode = 1; m_dir = u; m_age = 0; e_change = 1; e_on_off = u;
                end
            end else if (m_mode == 1) begin
                if (u && d) m_mode = 2;
                else if (!(m_dir ? u : d)) m_mode = 0;
                else begin
                    m_age++;
                    if (m_age == H || (m_age > H && (m_age - H) % R == 0)) e_change = 1;
                end
            end else begin
                if (!u && !d) m_mode = 0;
            end
            e_active = (m_mode == 1);
            // a level is accepted after D consecutive edges of disagreement
            if (m_s_up != m_db_up) begin
                m_run_up++;
                if (m_run_up == D) begin m_db_up = m_s_up; m_run_up = 0; end
            end else m_run_up = 0;
            if (m_s_dn != m_db_dn) begin
                m_run_dn++;
                if (m_run_dn == D) begin m_db_dn = m_s_dn; m_run_dn = 0; end
            end else m_run_dn = 0;
            m_s_up = m_sa_up; m_sa_up = bus.btn_up;
            m_s_dn = m_sa_dn; m_sa_dn = bus.btn_dn;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        obs3 = {bus.change, bus.on_off, bus.active};
        exp3 = {e_change, e_on_off, e_active};
        if (obs3 !== exp3) begin
            if (m_err == 0) begin
                m_err_cyc = cyc; m_err_got = obs3; m_err_exp = exp3;
            end
            m_err++;
        end
        if (bus.change === 1'b1) begin
            ev_q.push_back(cyc);
            ev_dir_q.push_back(bus.on_off);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_log();
        ev_q.delete();
        ev_dir_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        m_err = 0;
        for (int i = 0; i < 20; i++) begin
            bus.btn_up = 1'($urandom_range(0, 1));
            bus.btn_dn = 1'($urandom_range(0, 1));
            tick();
            n_cmp++;
            if (obs3 !== 3'b000) begin
                n_bad++;
                $display("FAIL reset_outputs cyc=%0d got=%b required=000", cyc, obs3);
            end
        end
        bus.btn_up = 1'b0;
        bus.btn_dn = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if ($isunknown(obs3)) begin
                n_bad++;
                $display("FAIL reset_release_x cyc=%0d got=%b required=no X", cyc, obs3);
            end
        end
    endtask

    task automatic test_bounce_hold();
        m_err = 0;
        clear_log();
        repeat (5) begin
            bus.btn_up = 1'b1; ticks(3);
            bus.btn_up = 1'b0; ticks(3);
        end
        bus.btn_up = 1'b1;
        ticks(1);
        n_cmp++;
        if (ev_q.size() !== 0) begin
            n_bad++;
            $display("FAIL bounce_no_event got=%0d events required=0", ev_q.size());
        end
        clear_log();
        start = cyc - 1;
        ticks(149);
        bus.btn_up = 1'b0;
        ticks(40);
        n_cmp++;
        if (ev_q.size() < 3) begin
            n_bad++;
            $display("FAIL hold_event_count got=%0d required>=3", ev_q.size());
        end else begin
            n_cmp++;
            if (ev_q[0] - start !== 19) begin
                n_bad++;
                $display("FAIL first_event_latency got=%0d required=19", ev_q[0] - start);
            end
            n_cmp++;
            if (ev_dir_q[0] !== 1'b1) begin
                n_bad++;
                $display("FAIL first_event_dir got=%0d required=1", ev_dir_q[0]);
            end
            n_cmp++;
            if (ev_q[1] - start !== 19 + H) begin
                n_bad++;
                $display("FAIL first_repeat got=%0d required=%0d", ev_q[1] - start, 19 + H);
            end
            n_cmp++;
            if (ev_q[2] - start !== 19 + H + R) begin
                n_bad++;
                $display("FAIL second_repeat got=%0d required=%0d", ev_q[2] - start, 19 + H + R);
            end
        end
        n_cmp++;
        if (m_err !== 0) begin
            n_bad++;
            $display("FAIL model_bounce_hold mismatches=%0d first cyc=%0d got=%b required=%b",
                     m_err, m_err_cyc, m_err_got, m_err_exp);
        end
    endtask

    task automatic test_short_press();
        m_err = 0;
        clear_log();
        bus.btn_dn = 1'b1; ticks(30);
        bus.btn_dn = 1'b0; ticks(40);
        n_cmp++;
        if (ev_q.size() !== 1 || ev_dir_q[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL short_press_dn events=%0d required=1 with on_off=0", ev_q.size());
        end
        n_cmp++;
        if (bus.active !== 1'b0) begin
            n_bad++;
            $display("FAIL short_press_active got=%b required=0", bus.active);
        end
        n_cmp++;
        if (m_err !== 0) begin
            n_bad++;
            $display("FAIL model_short_press mismatches=%0d first cyc=%0d got=%b required=%b",
                     m_err, m_err_cyc, m_err_got, m_err_exp);
        end
    endtask

    task automatic test_glitch();
        int act_seen;
        m_err = 0;
        act_seen = 0;
        clear_log();
        bus.btn_up = 1'b1;
        repeat (10) begin tick(); if (bus.active === 1'b1) act_seen++; end
        bus.btn_up = 1'b0;
        repeat (40) begin tick(); if (bus.active === 1'b1) act_seen++; end
        n_cmp++;
        if (ev_q.size() !== 0 || act_seen !== 0) begin
            n_bad++;
            $display("FAIL glitch_rejected events=%0d active_cycles=%0d required=0/0",
                     ev_q.size(), act_seen);
        end
        n_cmp++;
        if (m_err !== 0) begin
            n_bad++;
            $display("FAIL model_glitch mismatches=%0d first cyc=%0d got=%b required=%b",
                     m_err, m_err_cyc, m_err_got, m_err_exp);
        end
    endtask

    task automatic test_lock();
        m_err = 0;
        bus.btn_up = 1'b1; ticks(100);
        bus.btn_dn = 1'b1; ticks(20);
        clear_log();
        ticks(40);
        n_cmp++;
        if (ev_q.size() !== 0 || bus.active !== 1'b0) begin
            n_bad++;
            $display("FAIL lock_both events=%0d active=%b required=0/0", ev_q.size(), bus.active);
        end
        bus.btn_dn = 1'b0; ticks(40);
        n_cmp++;
        if (ev_q.size() !== 0 || bus.active !== 1'b0) begin
            n_bad++;
            $display("FAIL lock_one_left events=%0d active=%b required=0/0", ev_q.size(), bus.active);
        end
        bus.btn_up = 1'b0; ticks(40);
        clear_log();
        bus.btn_dn = 1'b1;
        start = cyc;
        ticks(30);
        bus.btn_dn = 1'b0; ticks(40);
        n_cmp++;
        if (ev_q.size() !== 1 || ev_dir_q[0] !== 1'b0 || ev_q[0] - start !== 19) begin
            n_bad++;
            $display("FAIL lock_exit_press events=%0d required=1 dn event at +19", ev_q.size());
        end
        n_cmp++;
        if (m_err !== 0) begin
            n_bad++;
            $display("FAIL model_lock mismatches=%0d first cyc=%0d got=%b required=%b",
                     m_err, m_err_cyc, m_err_got, m_err_exp);
        end
    endtask

    task automatic test_reset_mid_repeat();
        m_err = 0;
        bus.btn_up = 1'b1; ticks(90);
        rst = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if ({bus.change, bus.on_off, bus.active} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_async_drop got=%b required=000", {bus.change, bus.on_off, bus.active});
        end
        ticks(3);
        rst = 1'b1;
        clear_log();
        start = cyc;
        ticks(30);
        n_cmp++;
        if (ev_q.size() < 1 || ev_q[0] - start !== 19 || ev_q.size() !== 1) begin
            n_bad++;
            $display("FAIL reset_fresh_event events=%0d required=1 at +19", ev_q.size());
        end
        bus.btn_up = 1'b0; ticks(40);
        n_cmp++;
        if (m_err !== 0) begin
            n_bad++;
            $display("FAIL model_reset_mid mismatches=%0d first cyc=%0d got=%b required=%b",
                     m_err, m_err_cyc, m_err_got, m_err_exp);
        end
    endtask

    task automatic test_random();
        m_err = 0;
        for (int i = 0; i < 60; i++) begin
            bus.btn_up = 1'($urandom_range(0, 1));
            bus.btn_dn = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b0;
                model_reset();
                ticks($urandom_range(1, 3));
                rst = 1'b1;
            end
            ticks($urandom_range(1, 110));
        end
        bus.btn_up = 1'b0;
        bus.btn_dn = 1'b0;
        ticks(40);
        n_cmp++;
        if (m_err !== 0) begin
            n_bad++;
            $display("FAIL model_random mismatches=%0d first cyc=%0d got=%b required=%b",
                     m_err, m_err_cyc, m_err_got, m_err_exp);
        end
    endtask

    initial begin
        rst = 1'b0;
        bus.btn_up = 1'b0;
        bus.btn_dn = 1'b0;
        model_reset();
        test_reset();
        ticks(20);
        test_bounce_hold();
        test_short_press();
        test_glitch();
        test_lock();
        test_reset_mid_repeat();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
